// File: rtl/odd_seq_checker.sv
// Passive checker for an odd-sequence up/down counter: tracks q_in against the legal
// +/-2 walk over odd values and reports lock, error and wrap status.
module odd_seq_checker #(
  parameter int W        = 4,
  parameter int CW       = 8,
  parameter int RESYNC_N = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [W-1:0]  q_in,
  input  logic          dir,
  input  logic          clr,
  output logic          locked,
  output logic          err,
  output logic          err_sticky,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] wrap_cnt,
  output logic [W-1:0]  exp_q
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam int GW = $clog2(RESYNC_N + 1);
  localparam logic [W-1:0]  TWO     = W'(2);
  localparam logic [W-1:0]  ONE     = W'(1);
  localparam logic [W-1:0]  Q_MAX   = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] RUN_END = GW'(RESYNC_N - 1);

  state_t          state, state_d;
  logic [W-1:0]    prev, prev_d;
  logic            prev_dir, prev_dir_d;
  logic [GW-1:0]   good_run, good_run_d;
  logic            locked_d, err_d, err_sticky_d;
  logic [CW-1:0]   err_cnt_d, wrap_cnt_d;
  logic [W-1:0]    exp_q_d;

  logic [W-1:0]    step_prev, step_in;
  logic            is_odd, is_legal, is_wrap;
  logic            bad, take, wrap_inc;

  // Modular arithmetic makes 15+2 -> 1 and 1-2 -> 15 fall out naturally.
  assign step_prev = prev_dir ? prev - TWO : prev + TWO;
  assign step_in   = dir      ? q_in - TWO : q_in + TWO;
  assign is_odd    = q_in[0];
  assign is_legal  = is_odd && (q_in == step_prev);
  assign is_wrap   = prev_dir ? (prev == ONE) : (prev == Q_MAX);

  // NOTE: every signal is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state;
    prev_d       = prev;
    prev_dir_d   = prev_dir;
    good_run_d   = good_run;
    locked_d     = locked;
    err_sticky_d = err_sticky;
    err_cnt_d    = err_cnt;
    wrap_cnt_d   = wrap_cnt;
    exp_q_d      = exp_q;
    err_d        = 1'b0;
    bad          = 1'b0;
    take         = 1'b0;
    wrap_inc     = 1'b0;

    if (sample_en) begin
      unique case (state)
        IDLE: begin
          if (is_odd) begin
            state_d  = TRACK;
            locked_d = 1'b1;
            take     = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        TRACK: begin
          if (is_legal) begin
            take     = 1'b1;
            wrap_inc = is_wrap;
          end else begin
            bad        = 1'b1;
            state_d    = FAULT;
            locked_d   = 1'b0;
            good_run_d = '0;
            take       = is_odd;
          end
        end
        FAULT: begin
          if (is_legal) begin
            take     = 1'b1;
            wrap_inc = is_wrap;
            if (good_run == RUN_END) begin
              state_d    = TRACK;
              locked_d   = 1'b1;
              good_run_d = '0;
            end else begin
              good_run_d = good_run + 1'b1;
            end
          end else begin
            bad        = 1'b1;
            good_run_d = '0;
            take       = is_odd;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // An even sample never becomes the anchor; direction is captured together with prev.
    if (take) begin
      prev_d     = q_in;
      prev_dir_d = dir;
      exp_q_d    = step_in;
    end

    if (bad) begin
      err_d        = 1'b1;
      err_sticky_d = 1'b1;
      if (err_cnt != CNT_MAX) err_cnt_d = err_cnt + 1'b1;
    end
    if (wrap_inc && wrap_cnt != CNT_MAX) wrap_cnt_d = wrap_cnt + 1'b1;

    // Clear overrides a same-cycle increment; the err pulse itself is unaffected.
    if (clr) begin
      err_cnt_d    = '0;
      wrap_cnt_d   = '0;
      err_sticky_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      prev_dir   <= 1'b0;
      good_run   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
      exp_q      <= '0;
    end else begin
      state      <= state_d;
      prev       <= prev_d;
      prev_dir   <= prev_dir_d;
      good_run   <= good_run_d;
      locked     <= locked_d;
      err        <= err_d;
      err_sticky <= err_sticky_d;
      err_cnt    <= err_cnt_d;
      wrap_cnt   <= wrap_cnt_d;
      exp_q      <= exp_q_d;
    end
  end

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker (W=4, CW=2 so saturation is reachable, RESYNC_N=3).
module tb_odd_seq_checker;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic [W-1:0]  q_in = '0;
  logic          dir = 1'b0;
  logic          clr = 1'b0;
  logic          locked, err, err_sticky;
  logic [CW-1:0] err_cnt, wrap_cnt;
  logic [W-1:0]  exp_q;

  int checks = 0;
  int errors = 0;

  odd_seq_checker #(.W(W), .CW(CW), .RESYNC_N(3)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .q_in(q_in), .dir(dir), .clr(clr),
    .locked(locked), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .exp_q(exp_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One enabled sample; returns 1 ns after the edge that consumed it.
  task automatic sample(input logic [W-1:0] q, input logic d);
    sample_en = 1'b1;
    q_in      = q;
    dir       = d;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic gap(input int n);
    sample_en = 1'b0;
    q_in      = 4'd2;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_en = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Scenario 1: up run through the wrap, with a gap inside
    do_reset();
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    check("rst_exp_q", exp_q, 0);
    sample(4'd1, 1'b0);
    check("s1_locked_first", locked, 1);
    check("s1_exp_after_1", exp_q, 3);
    for (int v = 3; v <= 15; v += 2) begin
      sample(W'(v), 1'b0);
      check("s1_err_up", err, 0);
      if (v == 7) begin
        gap(2);
        check("s1_gap_err", err, 0);
        check("s1_gap_locked", locked, 1);
        check("s1_gap_exp", exp_q, 9);
      end
    end
    check("s1_exp_at_15", exp_q, 1);
    check("s1_wrap_before", wrap_cnt, 0);
    sample(4'd1, 1'b0);
    check("s1_wrap_err", err, 0);
    sample(4'd3, 1'b0);
    check("s1_wrap_cnt", wrap_cnt, 1);
    check("s1_exp_after_3", exp_q, 5);
    check("s1_locked_end", locked, 1);
    check("s1_sticky_end", err_sticky, 0);

    // Scenario 2: down run through the wrap, then a direction reversal
    do_reset();
    sample(4'd3, 1'b1);
    check("s2_exp_3dn", exp_q, 1);
    sample(4'd1, 1'b1);
    check("s2_exp_1dn", exp_q, 15);
    gap(1);
    sample(4'd15, 1'b1);
    check("s2_err_15", err, 0);
    check("s2_wrap_cnt", wrap_cnt, 1);
    sample(4'd13, 1'b0);
    check("s2_err_13", err, 0);
    check("s2_exp_13up", exp_q, 15);
    sample(4'd15, 1'b0);
    check("s2_err_rev", err, 0);
    check("s2_locked_rev", locked, 1);
    check("s2_wrap_final", wrap_cnt, 1);
    check("s2_cnt_final", err_cnt, 0);

    // Scenario 3: skip injected in TRACK, resync after three legal steps
    do_reset();
    sample(4'd1, 1'b0);
    sample(4'd3, 1'b0);
    sample(4'd5, 1'b0);
    sample(4'd9, 1'b0);
    check("s3_err_pulse", err, 1);
    check("s3_err_cnt", err_cnt, 1);
    check("s3_sticky", err_sticky, 1);
    check("s3_unlocked", locked, 0);
    check("s3_exp_anchor", exp_q, 11);
    gap(1);
    check("s3_err_gap_low", err, 0);
    sample(4'd11, 1'b0);
    check("s3_err_one_cycle", err, 0);
    check("s3_locked_1", locked, 0);
    gap(3);
    sample(4'd13, 1'b0);
    check("s3_locked_2", locked, 0);
    sample(4'd15, 1'b0);
    check("s3_relocked", locked, 1);
    check("s3_err_cnt_hold", err_cnt, 1);
    check("s3_sticky_hold", err_sticky, 1);
    check("s3_wrap_none", wrap_cnt, 0);

    // Scenario 4: even value in IDLE, then lock
    do_reset();
    sample(4'd6, 1'b0);
    check("s4_err_even", err, 1);
    check("s4_locked_even", locked, 0);
    check("s4_exp_even", exp_q, 0);
    sample(4'd7, 1'b0);
    check("s4_err_7", err, 0);
    check("s4_locked_7", locked, 1);
    check("s4_exp_7", exp_q, 9);

    // Scenario 5: error count saturation at CW=2, clear wins over increment
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample(W'(2 * i + 2), 1'b0);
      check("s5_err_pulse", err, 1);
      check("s5_err_cnt", err_cnt, (i < 3) ? i + 1 : 3);
    end
    clr = 1'b1;
    sample(4'd12, 1'b0);
    clr = 1'b0;
    check("s5_clr_err", err, 1);
    check("s5_clr_cnt", err_cnt, 0);
    check("s5_clr_sticky", err_sticky, 0);
    check("s5_clr_locked", locked, 0);

    // Scenario 6: asynchronous reset mid-run, then relock from IDLE
    do_reset();
    sample(4'd7, 1'b0);
    sample(4'd9, 1'b0);
    sample(4'd11, 1'b0);
    check("s6_pre_locked", locked, 1);
    check("s6_pre_exp", exp_q, 13);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_locked", locked, 0);
    check("s6_async_exp", exp_q, 0);
    check("s6_async_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    sample(4'd13, 1'b0);
    check("s6_relock", locked, 1);
    check("s6_relock_err", err, 0);
    check("s6_relock_exp", exp_q, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
